// File: rtl/output_pkt_scheduler_if.sv
// Port bundle of the output-port packet scheduler: four source-buffer heads
// with their pop strobes, plus the ready/valid output link and status pulses.
// The master modport is the scheduler; the slave modport is its environment.
interface output_pkt_scheduler_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W:0]   in_word_1;
    logic [DATA_W:0]   in_word_2;
    logic [DATA_W:0]   in_word_3;
    logic [DATA_W:0]   in_word_4;
    logic              pop_1;
    logic              pop_2;
    logic              pop_3;
    logic              pop_4;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        grant;
    logic              pkt_done;
    logic              err;

    modport master (
        input  in_word_1, in_word_2, in_word_3, in_word_4, out_ready,
        output pop_1, pop_2, pop_3, pop_4, out_data, out_valid, grant, pkt_done, err
    );

    modport slave (
        output in_word_1, in_word_2, in_word_3, in_word_4, out_ready,
        input  pop_1, pop_2, pop_3, pop_4, out_data, out_valid, grant, pkt_done, err
    );
endinterface

// File: rtl/output_pkt_scheduler.sv
// Packet-level round-robin scheduler for one switch output port.
// A source owns the link for a whole packet; the round-robin pointer only
// moves at packet boundaries, so packets never interleave on out_data.
// Optional stall watchdog: define OUTPUT_PKT_SCHEDULER_WATCHDOG_EN.
module output_pkt_scheduler #(
    parameter int DATA_W        = 32,
    parameter int LEN_W         = 16,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    output_pkt_scheduler_if.master bus
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t           state;
    logic [1:0]       rr_ptr;
    logic [1:0]       gidx;
    logic [3:0]       grant_q;
    logic [LEN_W-1:0] cnt;

    logic [DATA_W:0]  words [4];
    logic [3:0]       head_valid;

    assign words[0] = bus.in_word_1;
    assign words[1] = bus.in_word_2;
    assign words[2] = bus.in_word_3;
    assign words[3] = bus.in_word_4;

    assign head_valid = {words[3][DATA_W], words[2][DATA_W], words[1][DATA_W], words[0][DATA_W]};

    // Round-robin pick: first valid head at or after rr_ptr, plus its length.
    logic             found;
    logic [1:0]       pick;
    logic [1:0]       idx;
    logic [LEN_W-1:0] pick_len;
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        found    = 1'b0;
        pick     = rr_ptr;
        idx      = rr_ptr;
        pick_len = '0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && head_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        pick_len = words[pick][LEN_W+7:8];
        if (pick_len == '0) begin
            pick_len = LEN_W'(1);
        end
    end

    // Granted-source datapath; out_data is forced to 0 outside XFER so no
    // other source is ever visible on the link.
    logic            in_xfer;
    logic [DATA_W:0] g_word;
    logic            fire;
    logic            last;
    logic            timeout;

    assign in_xfer       = (state == XFER);
    assign g_word        = words[gidx];
    assign bus.out_valid = in_xfer & g_word[DATA_W];
    assign bus.out_data  = in_xfer ? g_word[DATA_W-1:0] : '0;
    assign fire          = bus.out_valid & bus.out_ready;
    assign last          = fire && (cnt == LEN_W'(1));

    assign bus.pop_1    = fire && (gidx == 2'd0);
    assign bus.pop_2    = fire && (gidx == 2'd1);
    assign bus.pop_3    = fire && (gidx == 2'd2);
    assign bus.pop_4    = fire && (gidx == 2'd3);
    assign bus.grant    = grant_q;
    assign bus.pkt_done = last;

`ifdef OUTPUT_PKT_SCHEDULER_WATCHDOG_EN
    // Counter only needs to reach STALL_TIMEOUT-1; the next idle cycle aborts.
    localparam int STALL_W = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT);

    logic [STALL_W-1:0] stall_cnt;

    assign timeout = in_xfer && !g_word[DATA_W] && (stall_cnt == STALL_W'(STALL_TIMEOUT - 1));
    assign bus.err = timeout;

    // Count consecutive cycles the granted source is empty mid-packet;
    // link backpressure (valid but not ready) does not count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!in_xfer || g_word[DATA_W] || timeout) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    // No watchdog: err is constant 0 and STALL_TIMEOUT has no effect.
    assign timeout = 1'b0;
    assign bus.err = 1'b0 & (STALL_TIMEOUT == 0);
`endif

    // Packet FSM: arbitrate in IDLE, stream one whole packet in XFER.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state   <= IDLE;
            rr_ptr  <= 2'd0;
            gidx    <= 2'd0;
            grant_q <= 4'b0000;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= XFER;
                        gidx    <= pick;
                        grant_q <= 4'b0001 << pick;
                        cnt     <= pick_len;
                    end
                end
                XFER: begin
                    if (fire) begin
                        cnt <= cnt - 1'b1;
                    end
                    if (last || timeout) begin
                        state   <= IDLE;
                        grant_q <= 4'b0000;
                        rr_ptr  <= gidx + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_output_pkt_scheduler.sv
// Self-checking bench for output_pkt_scheduler: per-source word buffers feed
// the DUT, a packet-level reference model predicts every output each cycle,
// and directed tests pin delivered words, ordering and timing literally.
module tb_output_pkt_scheduler;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int TMO    = 8;
    localparam int MEM_D  = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;

    output_pkt_scheduler_if #(.DATA_W(DATA_W)) bus ();

    output_pkt_scheduler #(
        .DATA_W(DATA_W),
        .LEN_W(LEN_W),
        .STALL_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Source buffers: wr advanced by the test sequence, rd by the driver.
    logic [DATA_W-1:0] mem [4][MEM_D];
    int wr [4];
    int rd [4];

    function automatic logic [DATA_W-1:0] hdr(input int s, input int len);
        return {4'(s), 4'h0, 16'(len), 8'h00};
    endfunction

    function automatic logic [DATA_W-1:0] dw(input int s, input int k);
        return {4'(s), 4'h0, 16'h0000, 8'(k)};
    endfunction

    task automatic push(input int s, input logic [DATA_W-1:0] w);
        mem[s-1][wr[s-1]] = w;
        wr[s-1]++;
    endtask

    task automatic push_pkt(input int s, input int len, input int nwords);
        push(s, hdr(s, len));
        for (int k = 1; k < nwords; k++) push(s, dw(s, k));
    endtask

    task automatic flush();
        for (int s = 0; s < 4; s++) wr[s] = rd[s];
    endtask

    function automatic logic [DATA_W:0] word_of(input int s);
        case (s)
            0:       return bus.in_word_1;
            1:       return bus.in_word_2;
            2:       return bus.in_word_3;
            default: return bus.in_word_4;
        endcase
    endfunction

    // Driver: just after each rising edge, retire popped heads and present
    // the new heads and out_ready.
    logic [3:0] pop_rec = 4'b0000;
    int ready_mode = 0;
    int cyc = 0;
    always @(posedge clk) begin
        logic [DATA_W:0] w [4];
        cyc++;
        #1;
        for (int s = 0; s < 4; s++) begin
            if (pop_rec[s]) rd[s]++;
            w[s] = (rd[s] < wr[s]) ? {1'b1, mem[s][rd[s]]} : '0;
        end
        bus.in_word_1 = w[0];
        bus.in_word_2 = w[1];
        bus.in_word_3 = w[2];
        bus.in_word_4 = w[3];
        bus.out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
    end

    // Reference model state: owner 0 = link free, else source 1..4.
    int m_owner = 0;
    int m_rem   = 0;
    int m_ptr   = 0;
    int m_stall = 0;

    // Observed DUT traffic.
    logic [DATA_W-1:0] dlv [MEM_D];
    int dlv_cyc [MEM_D];
    int n_dlv   = 0;
    int n_done  = 0;
    int done_at = 0;
    int n_err   = 0;
    int err_cyc = 0;

    // Compare process: mid-cycle, predict every output from the model and
    // the presented heads, compare, then advance the model one cycle.
    always @(negedge clk) begin
        logic [3:0]        exp_pop;
        logic [3:0]        exp_grant;
        logic              exp_valid;
        logic              exp_done;
        logic              exp_err;
        logic              fire;
        logic [DATA_W:0]   w;
        logic [3:0]        act_pop;
        int                g;
        int                s;
        int                nxt;
        int                len;

        act_pop = {bus.pop_4, bus.pop_3, bus.pop_2, bus.pop_1};
        if (!rst) begin
            m_owner = 0;
            m_rem   = 0;
            m_ptr   = 0;
            m_stall = 0;
            pop_rec = 4'b0000;
            check("rst out_valid", bus.out_valid, 0);
            check("rst pops", act_pop, 0);
            check("rst grant", bus.grant, 0);
            check("rst pkt_done", bus.pkt_done, 0);
            check("rst err", bus.err, 0);
        end else begin
            exp_pop   = 4'b0000;
            exp_grant = 4'b0000;
            exp_valid = 1'b0;
            exp_done  = 1'b0;
            exp_err   = 1'b0;
            w         = '0;
            if (m_owner == 0) begin
                nxt = 0;
                for (int i = 0; i < 4; i++) begin
                    s = (m_ptr + i) % 4;
                    w = word_of(s);
                    if (nxt == 0 && w[DATA_W]) begin
                        nxt   = s + 1;
                        len   = int'(w[LEN_W+7:8]);
                        m_rem = (len == 0) ? 1 : len;
                    end
                end
                m_owner = nxt;
            end else begin
                g         = m_owner - 1;
                w         = word_of(g);
                exp_grant = 4'(1 << g);
                exp_valid = w[DATA_W];
                fire      = exp_valid && bus.out_ready;
                exp_pop[g] = fire;
                exp_done  = fire && (m_rem == 1);
                if (exp_valid) check("out_data", bus.out_data, w[DATA_W-1:0]);
                if (fire) begin
                    m_rem--;
                    m_stall = 0;
                    if (m_rem == 0) begin
                        m_owner = 0;
                        m_ptr   = (g + 1) % 4;
                    end
                end else if (!exp_valid) begin
`ifdef OUTPUT_PKT_SCHEDULER_WATCHDOG_EN
                    m_stall++;
                    if (m_stall == TMO) begin
                        exp_err = 1'b1;
                        m_owner = 0;
                        m_ptr   = (g + 1) % 4;
                        m_stall = 0;
                    end
`endif
                end else begin
                    m_stall = 0;
                end
            end
            check("grant", bus.grant, exp_grant);
            check("out_valid", bus.out_valid, exp_valid);
            check("pops", act_pop, exp_pop);
            check("pkt_done", bus.pkt_done, exp_done);
            check("err", bus.err, exp_err);

            if (bus.out_valid && bus.out_ready) begin
                dlv[n_dlv]     = bus.out_data;
                dlv_cyc[n_dlv] = cyc;
                n_dlv++;
            end
            if (bus.pkt_done) begin
                n_done++;
                done_at = n_dlv;
            end
            if (bus.err) begin
                n_err++;
                err_cyc = cyc;
            end
            pop_rec = act_pop;
        end
    end

    task automatic wait_dlv(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (n_dlv < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, n_dlv >= n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int d0;
        int e0;
        int order [5];

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("reset grant", bus.grant, 4'b0000);
        check("reset out_valid", bus.out_valid, 0);
        check("reset pop_1", bus.pop_1, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // T1: source 2, len 3.
        base = n_dlv;
        d0   = n_done;
        push_pkt(2, 3, 3);
        @(posedge clk);
        #2;
        check("t1 arbitration cycle grant", bus.grant, 4'b0000);
        check("t1 arbitration cycle out_valid", bus.out_valid, 0);
        @(posedge clk);
        #2;
        check("t1 grant", bus.grant, 4'b0010);
        check("t1 pop_2", bus.pop_2, 1);
        wait_dlv(base + 3, 20, "t1 words delivered");
        check("t1 word0", dlv[base], hdr(2, 3));
        check("t1 word1", dlv[base+1], dw(2, 1));
        check("t1 word2", dlv[base+2], dw(2, 2));
        check("t1 consecutive pops", dlv_cyc[base+2] - dlv_cyc[base], 2);
        check("t1 done on 3rd word", done_at, base + 3);
        repeat (2) @(negedge clk);
        #1;
        check("t1 pkt_done count", n_done - d0, 1);
        check("t1 model pointer", m_ptr, 2);

        // T1b: pointer now at source 3, so 3 beats 1.
        base = n_dlv;
        push_pkt(1, 1, 1);
        push_pkt(3, 1, 1);
        wait_dlv(base + 2, 20, "t1b words delivered");
        check("t1b first", dlv[base], hdr(3, 1));
        check("t1b second", dlv[base+1], hdr(1, 1));

        // T2: all four valid from reset, len 2 each, plus a second from 1.
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        flush();
        push_pkt(1, 2, 2);
        push_pkt(2, 2, 2);
        push_pkt(3, 2, 2);
        push_pkt(4, 2, 2);
        push_pkt(1, 2, 2);
        repeat (2) @(posedge clk);
        #2;
        rst  = 1'b1;
        base = n_dlv;
        d0   = n_done;
        wait_dlv(base + 10, 80, "t2 words delivered");
        order = '{1, 2, 3, 4, 1};
        for (int p = 0; p < 5; p++) begin
            check("t2 header order", dlv[base+2*p], hdr(order[p], 2));
            check("t2 body order", dlv[base+2*p+1], dw(order[p], 1));
        end
        check("t2 span with bubbles", dlv_cyc[base+9] - dlv_cyc[base], 13);
        repeat (2) @(negedge clk);
        #1;
        check("t2 pkt_done count", n_done - d0, 5);

        // T3: source 1 len 4 with out_ready toggling.
        ready_mode = 1;
        base = n_dlv;
        push_pkt(1, 4, 4);
        wait_dlv(base + 4, 40, "t3 words delivered");
        repeat (6) @(negedge clk);
        #1;
        check("t3 transfer count", n_dlv - base, 4);
        check("t3 span every other cycle", dlv_cyc[base+3] - dlv_cyc[base], 6);
        check("t3 done on 4th word", done_at, base + 4);
        check("t3 last word", dlv[base+3], dw(1, 3));
        ready_mode = 0;

        // T4: len 0 on source 3 is a one-word packet.
        base = n_dlv;
        d0   = n_done;
        push(3, hdr(3, 0));
        push_pkt(3, 1, 1);
        wait_dlv(base + 2, 20, "t4 words delivered");
        repeat (2) @(negedge clk);
        #1;
        check("t4 first word", dlv[base], hdr(3, 0));
        check("t4 second word", dlv[base+1], hdr(3, 1));
        check("t4 separate packets", dlv_cyc[base+1] - dlv_cyc[base], 2);
        check("t4 pkt_done count", n_done - d0, 2);

        // T5: async reset after 2 of 5 words; restart from source 1.
        base = n_dlv;
        push_pkt(2, 5, 5);
        wait_dlv(base + 2, 20, "t5 two words delivered");
        @(posedge clk);
        #3;
        check("t5 valid before reset", bus.out_valid, 1);
        rst = 1'b0;
        #1;
        check("t5 async out_valid", bus.out_valid, 0);
        check("t5 async pop_2", bus.pop_2, 0);
        check("t5 async grant", bus.grant, 4'b0000);
        check("t5 words before reset", n_dlv - base, 2);
        flush();
        @(negedge clk);
        #1;
        push_pkt(4, 1, 1);
        push_pkt(1, 1, 1);
        @(posedge clk);
        #2;
        rst  = 1'b1;
        base = n_dlv;
        wait_dlv(base + 2, 20, "t5 restart words");
        check("t5 first after reset", dlv[base], hdr(1, 1));
        check("t5 second after reset", dlv[base+1], hdr(4, 1));

        // T6: source 4 stalls after its header.
        repeat (2) @(negedge clk);
        #1;
        base = n_dlv;
        d0   = n_done;
        e0   = n_err;
        push_pkt(4, 3, 1);
        wait_dlv(base + 1, 20, "t6 header delivered");
        push_pkt(1, 1, 1);
        repeat (20) @(negedge clk);
        #1;
`ifdef OUTPUT_PKT_SCHEDULER_WATCHDOG_EN
        check("t6 err count", n_err - e0, 1);
        check("t6 err at 8th idle cycle", err_cyc - dlv_cyc[base], TMO);
        check("t6 next packet source 1", dlv[base+1], hdr(1, 1));
        check("t6 truncated without done", n_done - d0, 1);
        check("t6 grant released", bus.grant, 4'b0000);
`else
        check("t6 grant held", bus.grant, 4'b1000);
        check("t6 no err", n_err - e0, 0);
        check("t6 no further words", n_dlv - base, 1);
        check("t6 no pkt_done", n_done - d0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
